// File: rtl/v2i_enable_sequencer.sv
// Power-up sequencer and supervisor for a single V2I brick.
// Drives the brick enable and test pins, qualifies the asynchronous ok flag,
// restarts the brick after a dropout or settle timeout, and latches a fault
// once the retry budget is used up.
module v2i_enable_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned DEBOUNCE      = 4,
  parameter int unsigned OFF_CYCLES    = 16,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_on,
  input  logic       ten_req,
  input  logic       clear_fault,
  input  logic       ok_v2i,
  output logic       enable_v2i,
  output logic       ten_v2i,
  output logic       ready,
  output logic       fault,
  output logic [2:0] retry_cnt
);

  localparam int unsigned DEB_W   = 4;
  localparam int unsigned RETRY_W = 3;

  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   OFF_LAST    = CNT_W'(OFF_CYCLES - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST    = DEB_W'(DEBOUNCE - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_ON       = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   timer_q;
  logic [CNT_W-1:0]   timer_d;
  logic [RETRY_W-1:0] retry_d;
  logic               fail_c;

  logic               ok_meta;
  logic               ok_s;
  logic [DEB_W-1:0]   deb_cnt;
  logic               ok_lvl;
  logic               deb_flip;
  logic               ok_q;

  // Two-flop synchronizer for the brick ok flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_meta <= 1'b0;
      ok_s    <= 1'b0;
    end else begin
      ok_meta <= ok_v2i;
      ok_s    <= ok_meta;
    end
  end

  // The current ok_s sample is the last one of the qualifying run, so the
  // qualified level is visible in the same cycle the run completes.
  always_comb begin
    deb_flip = (ok_s != ok_lvl) && (deb_cnt == DEB_LAST);
    ok_q     = enable_v2i && (deb_flip ? ok_s : ok_lvl);
  end

  // Debounce run counter and held qualified level; both idle while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt <= '0;
      ok_lvl  <= 1'b0;
    end else if (!enable_v2i) begin
      deb_cnt <= '0;
      ok_lvl  <= 1'b0;
    end else if (ok_s == ok_lvl) begin
      deb_cnt <= '0;
    end else if (deb_flip) begin
      deb_cnt <= '0;
      ok_lvl  <= ok_s;
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  // Next-state, timer and retry bookkeeping.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_cnt;
    fail_c  = 1'b0;

    unique case (state_q)
      ST_OFF: begin
        if (req_on) begin
          state_d = ST_SETTLE;
          timer_d = '0;
        end
      end

      ST_SETTLE: begin
        timer_d = timer_q + CNT_W'(1);
        if (!req_on) begin
          state_d = ST_OFF;
        end else if (ok_q) begin
          state_d = ST_ON;
        end else if (timer_q == SETTLE_LAST) begin
          fail_c = 1'b1;
        end
      end

      ST_ON: begin
        if (!req_on) begin
          state_d = ST_OFF;
        end else if (!ok_q) begin
          fail_c = 1'b1;
        end
      end

      ST_COOLDOWN: begin
        timer_d = timer_q + CNT_W'(1);
        if (timer_q == OFF_LAST) begin
          timer_d = '0;
          state_d = req_on ? ST_SETTLE : ST_OFF;
        end
      end

      ST_FAULT: begin
        if (clear_fault) begin
          state_d = ST_OFF;
        end
      end

      default: begin
        state_d = ST_OFF;
      end
    endcase

    // A failure either consumes a retry or, with none left, latches the fault.
    if (fail_c) begin
      timer_d = '0;
      if (retry_cnt == RETRY_MAX) begin
        state_d = ST_FAULT;
      end else begin
        retry_d = retry_cnt + RETRY_W'(1);
        state_d = ST_COOLDOWN;
      end
    end

    // Returning to OFF starts a fresh retry budget.
    if (state_d == ST_OFF) begin
      retry_d = '0;
    end
  end

  // State register and outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      timer_q    <= '0;
      retry_cnt  <= '0;
      enable_v2i <= 1'b0;
      ready      <= 1'b0;
      fault      <= 1'b0;
      ten_v2i    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      retry_cnt  <= retry_d;
      enable_v2i <= (state_d == ST_SETTLE) || (state_d == ST_ON);
      ready      <= (state_d == ST_ON);
      fault      <= (state_d == ST_FAULT);
      ten_v2i    <= ten_req && (state_q != ST_FAULT);
    end
  end

endmodule

// File: tb/tb_v2i_enable_sequencer.sv
// Directed bench for v2i_enable_sequencer with hand-derived cycle expectations.
module tb_v2i_enable_sequencer;

  localparam int unsigned SETTLE_CYCLES = 16;
  localparam int unsigned DEBOUNCE      = 4;
  localparam int unsigned OFF_CYCLES    = 8;
  localparam int unsigned MAX_RETRY     = 2;
  localparam int unsigned CNT_W         = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_on;
  logic       ten_req;
  logic       clear_fault;
  logic       ok_v2i;
  logic       enable_v2i;
  logic       ten_v2i;
  logic       ready;
  logic       fault;
  logic [2:0] retry_cnt;

  int checks = 0;
  int errors = 0;

  // {enable_v2i, ready, fault, retry_cnt}
  logic [5:0] obs;
  assign obs = {enable_v2i, ready, fault, retry_cnt};

  v2i_enable_sequencer #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .DEBOUNCE     (DEBOUNCE),
    .OFF_CYCLES   (OFF_CYCLES),
    .MAX_RETRY    (MAX_RETRY),
    .CNT_W        (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_on     (req_on),
    .ten_req    (ten_req),
    .clear_fault(clear_fault),
    .ok_v2i     (ok_v2i),
    .enable_v2i (enable_v2i),
    .ten_v2i    (ten_v2i),
    .ready      (ready),
    .fault      (fault),
    .retry_cnt  (retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apply_reset();
    req_on      = 1'b0;
    ten_req     = 1'b0;
    clear_fault = 1'b0;
    ok_v2i      = 1'b0;
    rst_n       = 1'b0;
    steps(2);
    rst_n       = 1'b1;
  endtask

  task automatic test_reset();
    req_on      = 1'b0;
    ten_req     = 1'b0;
    clear_fault = 1'b0;
    ok_v2i      = 1'b0;
    rst_n       = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({obs, ten_v2i} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want %b", {obs, ten_v2i}, 7'b0);
    end
    req_on  = 1'b1;
    ten_req = 1'b1;
    ok_v2i  = 1'b1;
    steps(3);
    checks++;
    if ({obs, ten_v2i} !== 7'b0) begin
      errors++;
      $display("FAIL reset_held got %b want %b", {obs, ten_v2i}, 7'b0);
    end
    req_on  = 1'b0;
    ten_req = 1'b0;
    ok_v2i  = 1'b0;
    rst_n   = 1'b1;
    step();
  endtask

  // Ends in ON with the debounce level settled high.
  task automatic test_nominal();
    apply_reset();
    req_on = 1'b1;
    step();  // edge 0
    checks++;
    if (obs !== 6'b100000) begin
      errors++;
      $display("FAIL nominal_enable_edge0 got %b want %b", obs, 6'b100000);
    end
    steps(2);  // edges 1,2
    ok_v2i = 1'b1;
    for (int e = 3; e <= 7; e++) begin
      step();
      checks++;
      if (obs !== 6'b100000) begin
        errors++;
        $display("FAIL nominal_settling edge %0d got %b want %b", e, obs, 6'b100000);
      end
    end
    step();  // edge 8
    checks++;
    if (obs !== 6'b110000) begin
      errors++;
      $display("FAIL nominal_ready_edge8 got %b want %b", obs, 6'b110000);
    end
  endtask

  // Runs from ON left by test_nominal.
  task automatic test_glitch();
    ok_v2i = 1'b0;
    steps(3);
    ok_v2i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (obs !== 6'b110000) begin
        errors++;
        $display("FAIL glitch_reject cycle %0d got %b want %b", k, obs, 6'b110000);
      end
    end
    ok_v2i = 1'b0;  // sampled low from edge M
    for (int k = 0; k <= 4; k++) begin
      step();
      checks++;
      if (obs !== 6'b110000) begin
        errors++;
        $display("FAIL dropout_hold edge M+%0d got %b want %b", k, obs, 6'b110000);
      end
    end
    step();  // edge M+5
    checks++;
    if (obs !== 6'b000001) begin
      errors++;
      $display("FAIL dropout_fall got %b want %b", obs, 6'b000001);
    end
    steps(7);  // M+12
    checks++;
    if (obs !== 6'b000001) begin
      errors++;
      $display("FAIL dropout_cooldown got %b want %b", obs, 6'b000001);
    end
    step();  // M+13: back into SETTLE
    checks++;
    if (obs !== 6'b100001) begin
      errors++;
      $display("FAIL dropout_resettle got %b want %b", obs, 6'b100001);
    end
    ok_v2i = 1'b1;
    steps(6);  // M+19: ON again, retry kept
    checks++;
    if (obs !== 6'b110001) begin
      errors++;
      $display("FAIL retry_kept_in_on got %b want %b", obs, 6'b110001);
    end
  endtask

  // Ends in FAULT with req_on=1.
  task automatic test_timeout();
    apply_reset();
    ok_v2i = 1'b0;
    req_on = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 16; c++) begin
        step();
        checks++;
        if (obs !== {3'b100, 3'(r)}) begin
          errors++;
          $display("FAIL timeout_high round %0d cycle %0d got %b want %b", r, c, obs, {3'b100, 3'(r)});
        end
      end
      step();
      if (r < 2) begin
        for (int c = 0; c < 8; c++) begin
          checks++;
          if (obs !== {3'b000, 3'(r + 1)}) begin
            errors++;
            $display("FAIL timeout_low round %0d cycle %0d got %b want %b", r, c, obs, {3'b000, 3'(r + 1)});
          end
          if (c < 7) step();
        end
      end else begin
        checks++;
        if (obs !== 6'b001010) begin
          errors++;
          $display("FAIL timeout_fault got %b want %b", obs, 6'b001010);
        end
      end
    end
    steps(5);
    checks++;
    if (obs !== 6'b001010) begin
      errors++;
      $display("FAIL fault_held got %b want %b", obs, 6'b001010);
    end
  endtask

  // Runs from FAULT left by test_timeout.
  task automatic test_fault_clear();
    ten_req = 1'b1;
    step();
    checks++;
    if ({obs, ten_v2i} !== 7'b0010100) begin
      errors++;
      $display("FAIL fault_ten_blocked got %b want %b", {obs, ten_v2i}, 7'b0010100);
    end
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    checks++;
    if ({obs, ten_v2i} !== 7'b0000000) begin
      errors++;
      $display("FAIL fault_clear_off got %b want %b", {obs, ten_v2i}, 7'b0000000);
    end
    step();
    checks++;
    if ({obs, ten_v2i} !== 7'b1000001) begin
      errors++;
      $display("FAIL fault_clear_settle got %b want %b", {obs, ten_v2i}, 7'b1000001);
    end
    ten_req = 1'b0;
  endtask

  task automatic test_req_drop();
    apply_reset();
    ok_v2i = 1'b0;
    req_on = 1'b1;
    steps(6);
    checks++;
    if (obs !== 6'b100000) begin
      errors++;
      $display("FAIL drop_settle_pre got %b want %b", obs, 6'b100000);
    end
    req_on = 1'b0;
    step();
    checks++;
    if (obs !== 6'b000000) begin
      errors++;
      $display("FAIL drop_settle_off got %b want %b", obs, 6'b000000);
    end
    req_on = 1'b1;
    step();    // edge 0
    steps(15); // edges 1..15
    step();    // edge 16: timeout
    checks++;
    if (obs !== 6'b000001) begin
      errors++;
      $display("FAIL drop_cd_enter got %b want %b", obs, 6'b000001);
    end
    req_on = 1'b0;
    steps(2);  // edges 17,18
    req_on = 1'b1;
    steps(3);  // edges 19..21, request ignored
    checks++;
    if (obs !== 6'b000001) begin
      errors++;
      $display("FAIL drop_cd_ignore got %b want %b", obs, 6'b000001);
    end
    req_on = 1'b0;
    steps(2);  // edges 22,23
    checks++;
    if (obs !== 6'b000001) begin
      errors++;
      $display("FAIL drop_cd_last got %b want %b", obs, 6'b000001);
    end
    step();    // edge 24: expiry to OFF
    checks++;
    if (obs !== 6'b000000) begin
      errors++;
      $display("FAIL drop_cd_off got %b want %b", obs, 6'b000000);
    end
    step();
    checks++;
    if (obs !== 6'b000000) begin
      errors++;
      $display("FAIL drop_off_stays got %b want %b", obs, 6'b000000);
    end
  endtask

  task automatic test_ten_and_reset();
    int n;
    apply_reset();
    ten_req = 1'b1;
    step();
    checks++;
    if (ten_v2i !== 1'b1) begin
      errors++;
      $display("FAIL ten_rise got %b want %b", ten_v2i, 1'b1);
    end
    ten_req = 1'b0;
    step();
    checks++;
    if (ten_v2i !== 1'b0) begin
      errors++;
      $display("FAIL ten_fall got %b want %b", ten_v2i, 1'b0);
    end
    ten_req = 1'b1;
    ok_v2i  = 1'b1;
    req_on  = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL ten_reach_on timeout got %b want %b", ready, 1'b1);
    end
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    checks++;
    if ({obs, ten_v2i} !== 7'b1100001) begin
      errors++;
      $display("FAIL clear_ignored_on got %b want %b", {obs, ten_v2i}, 7'b1100001);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({obs, ten_v2i} !== 7'b0000000) begin
      errors++;
      $display("FAIL async_reset_on got %b want %b", {obs, ten_v2i}, 7'b0000000);
    end
    step();
    rst_n   = 1'b1;
    req_on  = 1'b0;
    ten_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_glitch();
    test_timeout();
    test_fault_clear();
    test_req_drop();
    test_ten_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/v2i_enable_sequencer.md
# v2i_enable_sequencer

Digital power-up sequencer and supervisor for one voltage2current brick (gain-10 source V2I with its 100u P-mirror). It drives the brick's enable and test-enable pins and watches the brick's asynchronous `ok` flag. It requires `ok` to settle within a bounded window, restarts the brick after a dropout, and latches a fault after repeated failures. It sits between the loop-regulation control logic and the V2I instance.

## Interface
Parameters:
- `SETTLE_CYCLES`, 64: max cycles, counted from enable rise, for `ok` to qualify high.
- `DEBOUNCE`, 4: consecutive synchronized samples needed to qualify an `ok` rise or fall (1..15).
- `OFF_CYCLES`, 16: forced enable-low cooldown before a retry.
- `MAX_RETRY`, 3: failures tolerated before fault (0..7).
- `CNT_W`, 8: timer width; must hold max(SETTLE_CYCLES, OFF_CYCLES).

Ports:
- `clk`  in  1  block clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_on`  in  1  level request to power the V2I.
- `ten_req`  in  1  test-enable request.
- `clear_fault`  in  1  single-cycle pulse that exits FAULT.
- `ok_v2i`  in  1  brick `ok` flag; asynchronous to `clk`.
- `enable_v2i`  out  1  drives the brick enable; registered.
- `ten_v2i`  out  1  drives the brick test pin; registered.
- `ready`  out  1  brick on and `ok` qualified.
- `fault`  out  1  fault latched.
- `retry_cnt`  out  3  failures since the last OFF entry.

## Operation
- `ok_v2i` passes through a 2-flop synchronizer to give `ok_s`. A debounce counter gives `ok_q`:
  - `ok_q` rises after `DEBOUNCE` consecutive `ok_s`=1 samples.
  - `ok_q` falls after `DEBOUNCE` consecutive `ok_s`=0 samples.
  - The counter clears on every disagreement and whenever `enable_v2i`=0. `ok_q` is forced 0 while `enable_v2i`=0.
- States: OFF, SETTLE, ON, COOLDOWN, FAULT. The `enable_v2i` register is set/cleared on the same edge as each state transition (details below).
- OFF: `enable_v2i`=0, `retry_cnt` cleared on entry.
  - `req_on`=1 → SETTLE; `enable_v2i` set on the same edge; timer cleared.
- SETTLE: `enable_v2i`=1, timer increments.
  - `req_on`=0 → OFF.
  - Else `ok_q`=1 → ON.
  - Else timer reaches `SETTLE_CYCLES`-1 → failure.
- ON: `enable_v2i`=1, `ready`=1.
  - `req_on`=0 → OFF.
  - Else `ok_q`=0 → failure.
- Failure handling:
  - If `retry_cnt`==`MAX_RETRY` → FAULT.
  - Else `retry_cnt`+1 → COOLDOWN.
  - In both cases `enable_v2i` clears on the same edge.
- COOLDOWN: `enable_v2i`=0, timer counts `OFF_CYCLES`.
  - `req_on` is ignored until the count expires.
  - On expiry: `req_on`=1 → SETTLE, else → OFF.
- FAULT: `enable_v2i`=0, `fault`=1.
  - `clear_fault`=1 → OFF, which also clears `retry_cnt`.
  - `req_on` is ignored.
  - `clear_fault` is ignored in all other states.
- `ten_v2i` = registered(`ten_req` & state≠FAULT). It is independent of the sequence otherwise.
- Priority within a cycle: `req_on`=0 beats `ok_q` events, which beat timer expiry.
- `retry_cnt` saturates at `MAX_RETRY`. Reaching ON does not clear it; only OFF entry or `clear_fault` does.

## Timing
- Reset values: state OFF, all outputs 0, synchronizer, debounce and timer all 0.
- Reset mid-operation: `enable_v2i` drops asynchronously; no cooldown is applied.
- `req_on` sampled 1 at edge N → `enable_v2i`=1 after edge N.
- `ok_v2i` stable high from before edge M → `ok_s`=1 after edge M+1 → `ok_q`=1 after edge M+`DEBOUNCE` → `ready`=1 after edge M+`DEBOUNCE`+1.
- Dropout: `ok_v2i` low from edge M → `enable_v2i` and `ready` fall after edge M+`DEBOUNCE`+1.
- Settle timeout: `enable_v2i` falls exactly `SETTLE_CYCLES` edges after it rose.
- Cooldown: `enable_v2i` stays low exactly `OFF_CYCLES` cycles before SETTLE.
- All outputs are registered; no combinational paths from inputs to outputs.

## Test plan
Defaults for all scenarios: `SETTLE_CYCLES`=16, `DEBOUNCE`=4, `OFF_CYCLES`=8, `MAX_RETRY`=2.
- Nominal power-up: `req_on`=1 at edge 0, `ok_v2i`=1 from edge 3 → `enable_v2i` high from edge 0, `ready` high after edge 8, `retry_cnt`=0.
- Settle timeout: `ok_v2i` held 0 → `enable_v2i` high 16 cycles, low 8 cycles, then repeats. `retry_cnt` goes 1, 2. The third timeout sets `fault`=1 with `enable_v2i`=0 held.
- Glitch rejection: in ON, `ok_v2i` low for 3 cycles → `ready` stays 1. Low for 4+ cycles → `ready`/`enable_v2i` fall 5 edges after the drop, `retry_cnt`=1.
- Fault clear: in FAULT with `req_on`=1 → stays FAULT. `clear_fault` pulse → OFF, `retry_cnt`=0, then SETTLE on the next edge.
- Request drop during SETTLE and during COOLDOWN:
  - Drop in SETTLE → immediate OFF, no retry increment.
  - Drop in COOLDOWN → full 8-cycle cooldown completes, then OFF.
- Test pin and reset: `ten_req`=1 → `ten_v2i`=1 one edge later, and 0 while in FAULT. Async `rst_n` low in ON → all outputs 0 immediately.
